cart_backup_ctrl: RTL and testbench
===================================

CART_BACKUP_CTRL -- requirements
Module: cart_backup_ctrl

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 24'hFFFFFF, meaning the number of clk_sys cycles to wait for sd_ack before aborting.
REQ-002 Ports:
- clk_sys  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- img_mounted  in  1  save image mount strobe.
- img_readonly  in  1  image is write-protected.
- img_size  in  64  image size in bytes.
- has_save  in  1  cart has battery-backed RAM.
- ram_mask_file  in  8  last valid 512-byte LBA of the save.
- bk_save  in  1  save request level.
- sd_lba  out  32  block address.
- sd_rd  out  1  block read request.
- sd_wr  out  1  block write request.
- sd_ack  in  1  host transfer-active.
- sd_buff_addr  in  8  word index within block.
- sd_buff_dout  in  16  host-to-core word.
- sd_buff_wr  in  1  word strobe.
- sd_buff_din  out  16  core-to-host word.
- bk_addr  out  17  backup RAM word address.
- bk_wr  out  1  backup RAM write.
- bk_data  out  16  backup RAM write data.
- bk_q  in  16  backup RAM read data, 1-cycle latency.
- bk_loading  out  1  load in progress.
- busy  out  1  transfer in progress.
- err  out  1  sticky timeout flag.

Function
REQ-003 States SHALL be IDLE, REQ, XFER, NEXT.
REQ-004 bk_addr SHALL be {1'b0, sd_lba[7:0], sd_buff_addr} combinationally.
REQ-005 bk_data SHALL equal sd_buff_dout, and bk_wr SHALL equal sd_buff_wr & sd_ack & bk_loading.
REQ-006 sd_buff_din SHALL equal bk_q unmodified; the host samples one cycle after the address.
REQ-007 A rising edge of img_mounted SHALL set load_pend when img_size != 0 and has_save=1.
REQ-008 A rising edge of bk_save SHALL set save_pend when has_save=1, an image is mounted (img_size != 0 at last mount), and img_readonly=0.
REQ-009 Pending flags SHALL be captured in any state; edges arriving during busy are serviced after the current transfer.
REQ-010 In IDLE:
- load_pend SHALL take priority over save_pend.
- Starting a transfer clears the chosen flag, sets sd_lba=0, latches the direction, and enters REQ.
REQ-011 last_lba SHALL be min(ram_mask_file, img_size[16:9]-1); a load SHALL clamp to it, and a save SHALL use ram_mask_file.
REQ-012 In REQ, sd_rd (load) or sd_wr (save) SHALL be high; on sd_ack=1 the request SHALL drop the same cycle and the state SHALL go to XFER.
REQ-013 XFER SHALL wait for sd_ack=0, then go to NEXT.
REQ-014 In NEXT:
- If sd_lba==last_lba, go to IDLE.
- Otherwise, sd_lba SHALL increment by 1 and the state SHALL return to REQ.
REQ-015 A timeout counter SHALL reset on entry to REQ and SHALL count while sd_ack=0 in REQ. At ACK_TIMEOUT it SHALL drop the request, set err, and go to IDLE.
REQ-016 busy SHALL be 1 in every state except IDLE. bk_loading SHALL be busy & load direction.
REQ-017 err SHALL clear only on reset or on the start of a new transfer.
REQ-018 sd_lba[31:8] SHALL always be 0.

Reset
REQ-019 While reset=1 the block SHALL:
- Enter IDLE.
- Set sd_rd, sd_wr, bk_wr, busy, bk_loading and err to 0.
- Set sd_lba to 0.
- Clear load_pend and save_pend.
- Clear the edge detectors with their previous value taken as 0.
REQ-020 A reset mid-transfer SHALL abort without completing the block, and no bk_wr SHALL occur after reset is asserted.

Verification
REQ-021 Bench scenarios:
- Load 8KB: img_size=8192, ram_mask_file=0x0F, pulse img_mounted -> 16 sd_rd handshakes, LBAs 0..15; bk_wr per sd_buff_wr; bk_addr {0, lba, word}; busy drops after LBA 15.
- Short image: img_size=1024, ram_mask_file=0x3F -> exactly 2 blocks read (LBA 0,1).
- Save: bk_save rise, img_readonly=0, ram_mask_file=0x01 -> sd_wr for LBA 0 then 1. sd_buff_din equals bk_q of the word addressed the prior cycle; bk_wr stays 0.
- Readonly/no battery: bk_save rise with img_readonly=1, or has_save=0 -> no sd_wr, busy stays 0.
- Collision: bk_save rise during a load -> save starts in IDLE right after the load completes.
- Timeout and reset: ACK_TIMEOUT=16, no sd_ack -> sd_rd drops after 16 cycles, err=1. Reset asserted mid-XFER -> all outputs 0 next cycle.

Source files
------------

// File: rtl/cart_backup_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cart_backup_ctrl                                                           |
// | Streams cartridge battery RAM to/from a host-mounted save image by blocks.|
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module cart_backup_ctrl #(
  parameter logic [23:0] ACK_TIMEOUT = 24'hFFFFFF
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        img_mounted,
  input  logic        img_readonly,
  input  logic [63:0] img_size,
  input  logic        has_save,
  input  logic [7:0]  ram_mask_file,
  input  logic        bk_save,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic        sd_ack,
  input  logic [7:0]  sd_buff_addr,
  input  logic [15:0] sd_buff_dout,
  input  logic        sd_buff_wr,
  output logic [15:0] sd_buff_din,
  output logic [16:0] bk_addr,
  output logic        bk_wr,
  output logic [15:0] bk_data,
  input  logic [15:0] bk_q,
  output logic        bk_loading,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    NEXT = 2'd3
  } state_t;

  localparam logic [23:0] c_tmo_last = ACK_TIMEOUT - 24'd1;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_mount_d;
  logic        r_save_d;
  logic        r_mounted;
  logic        r_load_pend;
  logic        r_save_pend;
  logic        r_dir_load;
  logic [7:0]  r_lba;
  logic [7:0]  r_last_lba;
  logic [23:0] r_tmo_cnt;
  logic        r_err;

  logic        w_mount_rise;
  logic        w_save_rise;
  logic        w_start_load;
  logic        w_start_save;
  logic        w_timeout;
  logic        w_advance;
  logic        w_req;
  logic [7:0]  w_img_last;
  logic [7:0]  w_load_last;

  assign w_mount_rise = img_mounted & ~r_mount_d;
  assign w_save_rise  = bk_save & ~r_save_d;

  // A load never reads past the end of the image, even if the cart mask is larger.
  assign w_img_last  = img_size[16:9] - 8'd1;
  assign w_load_last = (ram_mask_file < w_img_last) ? ram_mask_file : w_img_last;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_start_load = 1'b0;
    w_start_save = 1'b0;
    w_timeout    = 1'b0;
    w_advance    = 1'b0;
    w_req        = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_load_pend) begin
          w_start_load = 1'b1;
          w_state_nxt  = REQ;
        end else if (r_save_pend) begin
          w_start_save = 1'b1;
          w_state_nxt  = REQ;
        end
      end
      REQ: begin
        if (sd_ack) begin
          w_state_nxt = XFER;
        end else begin
          w_req = 1'b1;
          if (r_tmo_cnt == c_tmo_last) begin
            w_timeout   = 1'b1;
            w_state_nxt = IDLE;
          end
        end
      end
      XFER: begin
        if (!sd_ack) begin
          w_state_nxt = NEXT;
        end
      end
      NEXT: begin
        if (r_lba == r_last_lba) begin
          w_state_nxt = IDLE;
        end else begin
          w_advance   = 1'b1;
          w_state_nxt = REQ;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_mount_d   <= 1'b0;
      r_save_d    <= 1'b0;
      r_mounted   <= 1'b0;
      r_load_pend <= 1'b0;
      r_save_pend <= 1'b0;
      r_dir_load  <= 1'b0;
      r_lba       <= 8'd0;
      r_last_lba  <= 8'd0;
      r_tmo_cnt   <= 24'd0;
      r_err       <= 1'b0;
    end else begin
      r_mount_d <= img_mounted;
      r_save_d  <= bk_save;
      if (w_mount_rise) begin
        r_mounted <= (img_size != 64'd0);
      end

      // Clear-then-set so an edge landing on the start cycle is not lost.
      if (w_start_load) begin
        r_load_pend <= 1'b0;
      end
      if (w_mount_rise && (img_size != 64'd0) && has_save) begin
        r_load_pend <= 1'b1;
      end
      if (w_start_save) begin
        r_save_pend <= 1'b0;
      end
      if (w_save_rise && has_save && r_mounted && !img_readonly) begin
        r_save_pend <= 1'b1;
      end

      if (w_start_load || w_start_save) begin
        r_lba      <= 8'd0;
        r_dir_load <= w_start_load;
        r_last_lba <= w_start_load ? w_load_last : ram_mask_file;
        r_tmo_cnt  <= 24'd0;
        r_err      <= 1'b0;
      end else if (w_advance) begin
        r_lba     <= r_lba + 8'd1;
        r_tmo_cnt <= 24'd0;
      end else if (w_req) begin
        r_tmo_cnt <= r_tmo_cnt + 24'd1;
      end

      if (w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  // Outputs are gated by reset so nothing escapes during the reset cycle itself.
  assign busy        = (r_state != IDLE) & ~reset;
  assign bk_loading  = busy & r_dir_load;
  assign sd_rd       = w_req & r_dir_load & ~reset;
  assign sd_wr       = w_req & ~r_dir_load & ~reset;
  assign err         = r_err & ~reset;
  assign sd_lba      = {24'd0, r_lba};
  assign bk_addr     = {1'b0, r_lba, sd_buff_addr};
  assign bk_data     = sd_buff_dout;
  assign bk_wr       = sd_buff_wr & sd_ack & bk_loading;
  assign sd_buff_din = bk_q;

endmodule
`default_nettype wire

// File: tb/tb_cart_backup_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_cart_backup_ctrl                                                        |
// | Scoreboard bench: host emulator, backup RAM model and block-order monitor. |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_cart_backup_ctrl;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        img_mounted;
  logic        img_readonly;
  logic [63:0] img_size;
  logic        has_save;
  logic [7:0]  ram_mask_file;
  logic        bk_save;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack;
  logic [7:0]  sd_buff_addr;
  logic [15:0] sd_buff_dout;
  logic        sd_buff_wr;
  logic [15:0] sd_buff_din;
  logic [16:0] bk_addr;
  logic        bk_wr;
  logic [15:0] bk_data;
  logic [15:0] bk_q;
  logic        bk_loading;
  logic        busy;
  logic        err;

  cart_backup_ctrl #(.ACK_TIMEOUT(24'd16)) dut (
    .clk_sys(clk_sys), .reset(reset), .img_mounted(img_mounted),
    .img_readonly(img_readonly), .img_size(img_size), .has_save(has_save),
    .ram_mask_file(ram_mask_file), .bk_save(bk_save), .sd_lba(sd_lba),
    .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr),
    .sd_buff_dout(sd_buff_dout), .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din),
    .bk_addr(bk_addr), .bk_wr(bk_wr), .bk_data(bk_data), .bk_q(bk_q),
    .bk_loading(bk_loading), .busy(busy), .err(err)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    bit       wr;
    bit [7:0] lba;
  } exp_t;

  exp_t     sb_q[$];
  int       checks = 0;
  int       errors = 0;
  int       blocks_done = 0;
  bit       host_en = 1'b1;
  bit       mdl_mounted = 1'b0;
  bit [7:0] cur_lba = 8'd0;

  function automatic logic [15:0] pat(input logic [16:0] a);
    return a[15:0] ^ 16'hA5C3 ^ {a[7:0], a[15:8]} ^ {15'd0, a[16]};
  endfunction

  // Backup RAM with one cycle of read latency, contents a fixed address hash.
  always @(posedge clk_sys) bk_q <= pat(bk_addr);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push(input bit wr, input int lba);
    exp_t e;
    e.wr  = wr;
    e.lba = 8'(lba);
    sb_q.push_back(e);
  endtask

  task automatic mount(input int size, input bit hs, output int n);
    img_size = 64'(size);
    has_save = hs;
    n = 0;
    if (hs && size != 0) begin
      n = size / 512;
      if (n > int'(ram_mask_file) + 1) n = int'(ram_mask_file) + 1;
      for (int i = 0; i < n; i++) push(1'b0, i);
    end
    mdl_mounted = (size != 0);
    @(negedge clk_sys); img_mounted = 1'b1;
    @(negedge clk_sys); img_mounted = 1'b0;
  endtask

  task automatic save_req(output int n);
    n = 0;
    if (has_save && mdl_mounted && !img_readonly) begin
      n = int'(ram_mask_file) + 1;
      for (int i = 0; i < n; i++) push(1'b1, i);
    end
    @(negedge clk_sys); bk_save = 1'b1;
    @(negedge clk_sys); bk_save = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int cyc = 0;
    int budget = (target - blocks_done + 1) * 400;
    while (blocks_done < target && cyc < budget) begin
      @(negedge clk_sys); #2;
      cyc++;
    end
    chk("blocks_done", blocks_done, target);
    repeat (4) @(negedge clk_sys);
    #2;
    chk("busy_end", busy, 1'b0);
    chk("sb_empty", sb_q.size(), 0);
  endtask

  task automatic idle_check(input int ncyc);
    int bad = 0;
    repeat (ncyc) begin
      @(negedge clk_sys); #2;
      if (busy || sd_rd || sd_wr || bk_wr) bad++;
    end
    chk("idle_cycles_active", bad, 0);
  endtask

  // Monitor: every new block request is matched against the next expected block.
  initial begin
    bit   prev;
    bit   req;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk_sys); #3;
      req = sd_rd | sd_wr;
      if (req && !prev) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req actual=rd%0d_wr%0d_lba%0h required=none", sd_rd, sd_wr, sd_lba);
        end else begin
          e = sb_q.pop_front();
          cur_lba = e.lba;
          chk("req_dir", {sd_rd, sd_wr}, e.wr ? 2'b01 : 2'b10);
          chk("req_lba", sd_lba, {24'd0, e.lba});
        end
      end
      prev = req;
    end
  end

  // Host emulator: acknowledges requests and moves 256 words per block.
  initial begin
    bit        is_load;
    bit [15:0] dv;
    forever begin
      @(negedge clk_sys);
      if (host_en && !reset && (sd_rd || sd_wr)) begin
        is_load = sd_rd;
        repeat ($urandom_range(1, 3)) @(negedge clk_sys);
        sd_ack = 1'b1;
        #1;
        chk("req_drop_on_ack", {sd_rd, sd_wr}, 2'b00);
        for (int w = 0; w < 256; w++) begin
          @(negedge clk_sys);
          sd_buff_addr = 8'(w);
          if (is_load) begin
            dv = 16'($urandom);
            sd_buff_dout = dv;
            sd_buff_wr = 1'b1;
            #1;
            chk("bk_wr_load", bk_wr, 1'b1);
            chk("bk_addr", bk_addr, {1'b0, cur_lba, 8'(w)});
            chk("bk_data", bk_data, dv);
          end else begin
            sd_buff_wr = 1'($urandom);
            #1;
            chk("bk_wr_save", bk_wr, 1'b0);
            chk("bk_loading_save", bk_loading, 1'b0);
            if (w > 0) chk("sd_buff_din", sd_buff_din, pat({1'b0, cur_lba, 8'(w - 1)}));
          end
        end
        @(negedge clk_sys);
        sd_buff_wr = 1'b0;
        sd_ack = 1'b0;
        blocks_done++;
      end
    end
  end

  initial begin
    #900us;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int n, n1, n2, base, cyc, gap;
    reset = 1'b1; img_mounted = 1'b0; img_readonly = 1'b0; img_size = 64'd0;
    has_save = 1'b1; ram_mask_file = 8'd0; bk_save = 1'b0; sd_ack = 1'b0;
    sd_buff_addr = 8'd0; sd_buff_dout = 16'd0; sd_buff_wr = 1'b0;
    repeat (3) @(negedge clk_sys);
    #2;
    chk("rst_sd_rd", sd_rd, 1'b0);
    chk("rst_sd_wr", sd_wr, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_bk_loading", bk_loading, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_sd_lba", sd_lba, 32'd0);
    @(negedge clk_sys); reset = 1'b0;

    // 8KB image, mask 0x0F: sixteen blocks
    ram_mask_file = 8'h0F;
    mount(8192, 1'b1, n);
    wait_done(blocks_done + n);

    // 1KB image clamps a large mask down to two blocks
    ram_mask_file = 8'h3F;
    mount(1024, 1'b1, n);
    wait_done(blocks_done + n);

    // Save of two blocks
    ram_mask_file = 8'h01;
    save_req(n);
    wait_done(blocks_done + n);

    // Write-protected image and missing battery produce nothing
    img_readonly = 1'b1;
    save_req(n);
    idle_check(20);
    img_readonly = 1'b0;
    has_save = 1'b0;
    save_req(n);
    idle_check(20);
    mount(4096, 1'b0, n);
    idle_check(20);

    // Save request arriving during a load runs right after it
    ram_mask_file = 8'h03;
    base = blocks_done;
    mount(8192, 1'b1, n1);
    repeat (30) @(negedge clk_sys);
    save_req(n2);
    cyc = 0;
    while (blocks_done < base + n1 && cyc < 3000) begin
      @(negedge clk_sys); #2;
      cyc++;
    end
    gap = 0;
    while (!sd_wr && gap < 10) begin
      @(negedge clk_sys); #2;
      gap++;
    end
    chk("collide_gap_ok", gap <= 4, 1'b1);
    wait_done(base + n1 + n2);

    // Randomised loads and saves
    for (int it = 0; it < 6; it++) begin
      ram_mask_file = 8'($urandom_range(0, 5));
      if ($urandom_range(0, 1) == 0) begin
        mount($urandom_range(1, 40) * 512 + $urandom_range(0, 511), 1'($urandom_range(0, 3) != 0), n);
      end else begin
        img_readonly = 1'($urandom_range(0, 3) == 0);
        save_req(n);
        img_readonly = 1'b0;
      end
      if (n == 0) idle_check(20);
      else wait_done(blocks_done + n);
      has_save = 1'b1;
    end

    // Request timeout: no host acknowledge
    host_en = 1'b0;
    ram_mask_file = 8'h00;
    mount(512, 1'b1, n);
    cyc = 0;
    #2;
    while (!sd_rd && cyc < 20) begin
      @(negedge clk_sys); #2;
      cyc++;
    end
    cyc = 0;
    while (sd_rd && cyc < 40) begin
      cyc++;
      @(negedge clk_sys); #2;
    end
    chk("tmo_req_cycles", cyc, 16);
    chk("tmo_err", err, 1'b1);
    chk("tmo_busy", busy, 1'b0);
    repeat (5) @(negedge clk_sys);
    #2;
    chk("err_sticky", err, 1'b1);

    // Reset in the middle of a block transfer
    ram_mask_file = 8'h01;
    mount(1024, 1'b1, n);
    cyc = 0;
    #2;
    while (!sd_rd && cyc < 20) begin
      @(negedge clk_sys); #2;
      cyc++;
    end
    chk("rst_test_req", sd_rd, 1'b1);
    chk("err_clear_on_start", err, 1'b0);
    @(negedge clk_sys); sd_ack = 1'b1;
    for (int w = 0; w < 3; w++) begin
      @(negedge clk_sys);
      sd_buff_addr = 8'(w);
      sd_buff_dout = 16'($urandom);
      sd_buff_wr = 1'b1;
    end
    @(negedge clk_sys); reset = 1'b1;
    #1;
    chk("mid_rst_bk_wr", bk_wr, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_loading", bk_loading, 1'b0);
    @(negedge clk_sys); #1;
    chk("post_rst_bk_wr", bk_wr, 1'b0);
    chk("post_rst_busy", busy, 1'b0);
    chk("post_rst_rdwr", {sd_rd, sd_wr}, 2'b00);
    chk("post_rst_lba", sd_lba, 32'd0);
    chk("post_rst_err", err, 1'b0);
    reset = 1'b0;
    sd_ack = 1'b0;
    sd_buff_wr = 1'b0;
    sb_q.delete();
    idle_check(10);

    chk("final_sb_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
